// File: rtl/shell_pkg.sv
// Shared types and constants for the PS HP port read-path logic.
package shell_pkg;

  localparam int unsigned AXI_LEN_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from last_grant+1.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic             gnt_valid,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_valid  = 1'b0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    cand       = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = IDX_W'((32'(last_grant) + off) % N_REQ);
      if (!gnt_valid && req[cand]) begin
        gnt_valid        = 1'b1;
        gnt_onehot[cand] = 1'b1;
        gnt_idx          = cand;
      end
    end
  end

endmodule

// File: rtl/axi_hp_rd_arbiter.sv
// Shares one PS AXI HP read port among N_REQ requesters, one burst outstanding at a time.
// R data is broadcast; only the granted requester sees rvalid.
module axi_hp_rd_arbiter
  import shell_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_arvalid,
  output logic [N_REQ-1:0]              req_arready,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   req_araddr,
  input  logic [N_REQ*AXI_LEN_W-1:0]    req_arlen,
  output logic [N_REQ-1:0]              req_rvalid,
  input  logic [N_REQ-1:0]              req_rready,
  output logic [DATA_WIDTH-1:0]         req_rdata,
  output logic                          req_rlast,
  output logic [1:0]                    req_rresp,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  output logic [ADDR_WIDTH-1:0]         m_araddr,
  output logic [AXI_LEN_W-1:0]          m_arlen,
  input  logic                          m_rvalid,
  output logic                          m_rready,
  input  logic [DATA_WIDTH-1:0]         m_rdata,
  input  logic                          m_rlast,
  input  logic [1:0]                    m_rresp,
  output logic                          len_err
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  arb_state_t             state_q;
  logic [IDX_W-1:0]       last_grant_q;
  logic [IDX_W-1:0]       grant_idx_q;
  logic [N_REQ-1:0]       grant_oh_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [AXI_LEN_W-1:0]   len_q;
  logic [AXI_LEN_W-1:0]   beat_cnt_q;
  logic                   m_arvalid_q;
  logic                   len_err_q;

  logic                   pick_valid;
  logic [N_REQ-1:0]       pick_oh;
  logic [IDX_W-1:0]       pick_idx;
  logic                   in_addr;
  logic                   in_data;
  logic                   beat;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req        (req_arvalid),
    .last_grant (last_grant_q),
    .gnt_valid  (pick_valid),
    .gnt_onehot (pick_oh),
    .gnt_idx    (pick_idx)
  );

  // Gate with rst so handshakes are suppressed in the reset cycle itself.
  assign in_addr = (state_q == StAddr) && !rst;
  assign in_data = (state_q == StData) && !rst;
  assign beat    = in_data && m_rvalid && m_rready;

  assign req_arready = {N_REQ{in_addr && m_arready}} & grant_oh_q;
  assign req_rvalid  = {N_REQ{in_data && m_rvalid}} & grant_oh_q;
  assign m_rready    = in_data && |(grant_oh_q & req_rready);
  assign req_rdata   = m_rdata;
  assign req_rlast   = m_rlast;
  assign req_rresp   = m_rresp;
  assign m_arvalid   = m_arvalid_q && !rst;
  assign m_araddr    = addr_q;
  assign m_arlen     = len_q;
  assign len_err     = len_err_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= IDX_W'(N_REQ - 1);
      grant_idx_q  <= '0;
      grant_oh_q   <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      m_arvalid_q  <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pick_valid) begin
            grant_idx_q <= pick_idx;
            grant_oh_q  <= pick_oh;
            addr_q      <= req_araddr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            len_q       <= req_arlen[pick_idx*AXI_LEN_W +: AXI_LEN_W];
            m_arvalid_q <= 1'b1;
            state_q     <= StAddr;
          end
        end
        StAddr: begin
          if (m_arready) begin
            m_arvalid_q <= 1'b0;
            beat_cnt_q  <= '0;
            state_q     <= StData;
          end
        end
        StData: begin
          if (beat) begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
            if (m_rlast) begin
              state_q      <= StIdle;
              last_grant_q <= grant_idx_q;
              len_err_q    <= (beat_cnt_q != len_q);
            end else if (beat_cnt_q == len_q) begin
              // Slave overran the requested length; keep draining until rlast.
              len_err_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_hp_rd_arbiter.sv
// Scoreboard bench for axi_hp_rd_arbiter with a simple HP slave model.
module tb_axi_hp_rd_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_arvalid;
  logic [N-1:0]    req_arready;
  logic [N*AW-1:0] req_araddr;
  logic [N*8-1:0]  req_arlen;
  logic [N-1:0]    req_rvalid;
  logic [N-1:0]    req_rready;
  logic [DW-1:0]   req_rdata;
  logic            req_rlast;
  logic [1:0]      req_rresp;
  logic            m_arvalid;
  logic            m_arready;
  logic [AW-1:0]   m_araddr;
  logic [7:0]      m_arlen;
  logic            m_rvalid;
  logic            m_rready;
  logic [DW-1:0]   m_rdata;
  logic            m_rlast;
  logic [1:0]      m_rresp;
  logic            len_err;

  always #5 clk = ~clk;

  axi_hp_rd_arbiter #(
    .N_REQ      (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_arvalid (req_arvalid),
    .req_arready (req_arready),
    .req_araddr  (req_araddr),
    .req_arlen   (req_arlen),
    .req_rvalid  (req_rvalid),
    .req_rready  (req_rready),
    .req_rdata   (req_rdata),
    .req_rlast   (req_rlast),
    .req_rresp   (req_rresp),
    .m_arvalid   (m_arvalid),
    .m_arready   (m_arready),
    .m_araddr    (m_araddr),
    .m_arlen     (m_arlen),
    .m_rvalid    (m_rvalid),
    .m_rready    (m_rready),
    .m_rdata     (m_rdata),
    .m_rlast     (m_rlast),
    .m_rresp     (m_rresp),
    .len_err     (len_err)
  );

  typedef struct {int idx; logic [AW-1:0] addr; logic [7:0] len;} ar_t;
  typedef struct {int idx; logic [DW-1:0] data; logic last;} beat_t;

  ar_t   ar_q[$];
  beat_t beat_q[$];
  int    err_log[$];

  int n_checks = 0;
  int n_pass   = 0;
  int beats_done = 0;
  int arready_pulses = 0;

  // Slave and stimulus knobs
  int            ar_delay = 0;
  int            ar_wait = 0;
  int            rlast_at = 0;
  bit            rr_toggle = 0;
  bit            drop_on_accept = 1;
  bit            r_active = 0;
  int            r_beat = 0;
  int            r_total = 0;
  logic [AW-1:0] r_addr = '0;
  bit            chk_gap = 0;
  bit            prev_wait = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [7:0]    prev_len = '0;

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [7:0] l);
    req_araddr[i*AW +: AW] = a;
    req_arlen[i*8 +: 8]    = l;
  endtask

  task automatic push_burst(input int i, input logic [AW-1:0] a, input logic [7:0] l,
                            input int total);
    ar_t   e;
    beat_t b;
    e.idx = i; e.addr = a; e.len = l;
    ar_q.push_back(e);
    for (int k = 0; k < total; k++) begin
      b.idx  = i;
      b.data = {a, 32'(k)};
      b.last = (k == total - 1);
      beat_q.push_back(b);
    end
  endtask

  // One clock: monitor at negedge, then update slave/inputs just after posedge.
  task automatic tick();
    logic         ar_hs, r_hs, hit;
    logic [N-1:0] acc_mask, oh;
    ar_t          e;
    beat_t        b;
    @(negedge clk);
    ar_hs    = m_arvalid && m_arready;
    r_hs     = m_rvalid && m_rready;
    acc_mask = req_arready & req_arvalid;
    if (len_err) err_log.push_back(beats_done);
    if (req_arready != '0) arready_pulses++;
    if (chk_gap) begin
      n_checks++;
      if (m_arvalid !== 1'b0) $display("FAIL idle_gap: m_arvalid=%b required 0", m_arvalid);
      else n_pass++;
    end
    chk_gap = r_hs && m_rlast;
    if (prev_wait) begin
      n_checks++;
      if (m_arvalid !== 1'b1 || m_araddr !== prev_addr || m_arlen !== prev_len)
        $display("FAIL ar_stable: valid=%b addr=%h len=%0d required 1 %h %0d",
                 m_arvalid, m_araddr, m_arlen, prev_addr, prev_len);
      else n_pass++;
    end
    prev_wait = m_arvalid && !m_arready;
    prev_addr = m_araddr;
    prev_len  = m_arlen;
    if (ar_hs || req_arready != '0) begin
      n_checks++;
      if (!ar_hs || ar_q.size() == 0) begin
        $display("FAIL ar_unexpected: arhs=%b arready=%b queued=%0d", ar_hs, req_arready,
                 ar_q.size());
      end else begin
        e  = ar_q.pop_front();
        oh = '0;
        oh[e.idx] = 1'b1;
        if (m_araddr !== e.addr || m_arlen !== e.len || req_arready !== oh)
          $display("FAIL ar_grant: addr=%h len=%0d arready=%b required %h %0d %b",
                   m_araddr, m_arlen, req_arready, e.addr, e.len, oh);
        else n_pass++;
      end
    end
    hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req_rvalid[i] && req_rready[i]) begin
        hit = 1'b1;
        n_checks++;
        if (beat_q.size() == 0) begin
          $display("FAIL beat_unexpected: requester %0d data=%h", i, req_rdata);
        end else begin
          b = beat_q.pop_front();
          if (i != b.idx || req_rdata !== b.data || req_rlast !== b.last)
            $display("FAIL beat: req=%0d data=%h last=%b required %0d %h %b",
                     i, req_rdata, req_rlast, b.idx, b.data, b.last);
          else n_pass++;
        end
      end
    end
    if (r_hs || hit || req_rvalid != '0) begin
      n_checks++;
      if (r_hs !== hit || $countones(req_rvalid) > 1)
        $display("FAIL r_route: m_hs=%b req_hs=%b rvalid=%b required matched one-hot",
                 r_hs, hit, req_rvalid);
      else n_pass++;
    end
    if (r_hs) beats_done++;
    @(posedge clk);
    #1;
    if (drop_on_accept) req_arvalid = req_arvalid & ~acc_mask;
    if (ar_hs) begin
      r_active = 1;
      r_beat   = 0;
      r_addr   = m_araddr;
      r_total  = (rlast_at > 0) ? rlast_at : int'(m_arlen) + 1;
    end else if (r_hs) begin
      r_beat++;
      if (r_beat == r_total) r_active = 0;
    end
    m_rvalid = r_active;
    m_rdata  = {r_addr, 32'(r_beat)};
    m_rlast  = r_active && (r_beat == r_total - 1);
    if (m_arvalid) begin
      if (ar_wait >= ar_delay) m_arready = 1'b1;
      else begin
        m_arready = 1'b0;
        ar_wait++;
      end
    end else begin
      m_arready = 1'b0;
      ar_wait   = 0;
    end
    req_rready = rr_toggle ? ~req_rready : '1;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((beat_q.size() != 0 || ar_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    n_checks++;
    if (beat_q.size() != 0 || ar_q.size() != 0)
      $display("FAIL %s_timeout: %0d beats %0d ars outstanding, required 0", name,
               beat_q.size(), ar_q.size());
    else n_pass++;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    req_arvalid = '0;
    r_active    = 0;
    m_rvalid    = 1'b0;
    m_rlast     = 1'b0;
    beat_q.delete();
    ar_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_checks++;
    if ({m_arvalid, m_rready, req_arready, req_rvalid, len_err} !== '0)
      $display("FAIL reset_outputs: arvalid=%b rready=%b arready=%b rvalid=%b err=%b required 0",
               m_arvalid, m_rready, req_arready, req_rvalid, len_err);
    else n_pass++;
    do_reset();
    tick();
    n_checks++;
    if (m_arvalid !== 1'b0) $display("FAIL reset_idle: m_arvalid=%b required 0", m_arvalid);
    else n_pass++;
  endtask

  task automatic test_single();
    int b0 = beats_done;
    int e0 = err_log.size();
    set_req(1, 32'h1000_0000, 8'd3);
    push_burst(1, 32'h1000_0000, 8'd3, 4);
    req_arvalid[1] = 1'b1;
    tick();
    n_checks++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h1000_0000)
      $display("FAIL single_latency: arvalid=%b addr=%h required 1 10000000", m_arvalid,
               m_araddr);
    else n_pass++;
    wait_idle(50, "single");
    tick();
    tick();
    n_checks++;
    if (beats_done - b0 != 4 || err_log.size() != e0)
      $display("FAIL single_result: beats=%0d errs=%0d required 4 0", beats_done - b0,
               err_log.size() - e0);
    else n_pass++;
  endtask

  task automatic test_fairness();
    int order[6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 32'h3000_0000 + 32'(i) * 32'h100, 8'd0);
    foreach (order[k]) push_burst(order[k], 32'h3000_0000 + 32'(order[k]) * 32'h100, 8'd0, 1);
    drop_on_accept = 0;
    req_arvalid    = '1;
    wait_idle(100, "fairness");
    req_arvalid    = '0;
    drop_on_accept = 1;
    tick();
    tick();
    n_checks++;
    if (m_arvalid !== 1'b0) $display("FAIL fairness_stop: m_arvalid=%b required 0", m_arvalid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int p0 = arready_pulses;
    int b0 = beats_done;
    ar_delay  = 5;
    rr_toggle = 1;
    set_req(2, 32'h2000_0040, 8'd7);
    push_burst(2, 32'h2000_0040, 8'd7, 8);
    req_arvalid[2] = 1'b1;
    wait_idle(100, "backpressure");
    n_checks++;
    if (arready_pulses - p0 != 1 || beats_done - b0 != 8)
      $display("FAIL backpressure_counts: arready pulses=%0d beats=%0d required 1 8",
               arready_pulses - p0, beats_done - b0);
    else n_pass++;
    ar_delay  = 0;
    rr_toggle = 0;
    tick();
  endtask

  task automatic test_len_err();
    int b0;
    // Early rlast: arlen 3, last on beat 2.
    err_log.delete();
    b0       = beats_done;
    rlast_at = 2;
    set_req(3, 32'h4000_0000, 8'd3);
    push_burst(3, 32'h4000_0000, 8'd3, 2);
    req_arvalid[3] = 1'b1;
    wait_idle(50, "len_short");
    tick();
    tick();
    n_checks++;
    if (err_log.size() != 1 || err_log[0] != b0 + 2 || m_arvalid !== 1'b0)
      $display("FAIL len_short: pulses=%0d arvalid=%b required 1 pulse after beat 2, idle",
               err_log.size(), m_arvalid);
    else n_pass++;
    // Late rlast: arlen 1, last on beat 3 (overrun at beat 2, mismatch at last).
    err_log.delete();
    b0       = beats_done;
    rlast_at = 3;
    set_req(0, 32'h4000_1000, 8'd1);
    push_burst(0, 32'h4000_1000, 8'd1, 3);
    req_arvalid[0] = 1'b1;
    wait_idle(50, "len_long");
    tick();
    tick();
    n_checks++;
    if (err_log.size() != 2 || err_log[0] != b0 + 2 || err_log[1] != b0 + 3)
      $display("FAIL len_long: pulses=%0d first=%0d required 2 pulses after beats 2 and 3",
               err_log.size(), (err_log.size() > 0) ? err_log[0] - b0 : -1);
    else n_pass++;
    rlast_at = 0;
  endtask

  task automatic test_reset_mid();
    int b0 = beats_done;
    int n  = 0;
    set_req(1, 32'h5000_0000, 8'd7);
    push_burst(1, 32'h5000_0000, 8'd7, 8);
    req_arvalid[1] = 1'b1;
    while (beats_done < b0 + 2 && n < 50) begin
      tick();
      n++;
    end
    rst         = 1'b1;
    r_active    = 0;
    m_rvalid    = 1'b0;
    m_rlast     = 1'b0;
    req_arvalid = '0;
    beat_q.delete();
    ar_q.delete();
    tick();
    n_checks++;
    if (beats_done - b0 != 2 || {m_arvalid, m_rready, req_arready, req_rvalid, len_err} !== '0)
      $display("FAIL reset_mid: beats=%0d outs=%b required 2 and all 0", beats_done - b0,
               {m_arvalid, m_rready, req_arready, req_rvalid, len_err});
    else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++;
    if (m_arvalid !== 1'b0 || req_rvalid !== '0)
      $display("FAIL reset_mid_idle: arvalid=%b rvalid=%b required 0", m_arvalid, req_rvalid);
    else n_pass++;
    set_req(0, 32'h6000_0000, 8'd1);
    set_req(2, 32'h6000_0200, 8'd0);
    push_burst(0, 32'h6000_0000, 8'd1, 2);
    push_burst(2, 32'h6000_0200, 8'd0, 1);
    req_arvalid = 4'b0101;
    wait_idle(60, "reset_mid_regrant");
    tick();
  endtask

  initial begin
    rst         = 1'b1;
    req_arvalid = '0;
    req_araddr  = '0;
    req_arlen   = '0;
    req_rready  = '1;
    m_arready   = 1'b0;
    m_rvalid    = 1'b0;
    m_rdata     = '0;
    m_rlast     = 1'b0;
    m_rresp     = 2'b00;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_len_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
